// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity/stop) feeding a first-word-fall-through
// receive FIFO with a valid/ready read port and framing/parity/overrun reporting.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 1736,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int DEPTH        = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       rx,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       frame_err,
    output logic                       parity_err,
    output logic                       overrun,
    input  logic                       clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP   = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   FULL_COUNT  = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rxs_q, armed_q;
    logic [1:0]             flush_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_bad_q, par_bad_d, ferr_q, ferr_d;
    logic                   frame_err_q, parity_err_q, overrun_q;
    logic                   push_req, fe_set, pe_set, stop_bad;
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            count_q;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic                   full, pop, push;

    // flush_q marks when rxs_q carries a real line sample rather than its reset value
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            flush_q   <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            flush_q   <= {flush_q[0], 1'b1};
            armed_q   <= armed_q | (flush_q[1] & rxs_q);
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            par_bad_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            par_bad_q <= par_bad_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        ferr_d    = ferr_q;
        push_req  = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        stop_bad  = ferr_q | ~rxs_q;
        if (state_q == S_IDLE) begin
            if (armed_q && !rxs_q) begin
                state_d = S_START;
                cnt_d   = HALF_RELOAD;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = FULL_RELOAD;
            case (state_q)
                S_START: begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_d     = '0;
                        par_bad_d = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
                S_PAR: begin
                    par_bad_d = (PARITY == 1) ? ~(^shift_q ^ rxs_q) : (^shift_q ^ rxs_q);
                    state_d   = S_STOP;
                end
                S_STOP: begin
                    ferr_d = stop_bad;
                    if (bit_q == LAST_STOP) begin
                        state_d  = S_IDLE;
                        fe_set   = stop_bad;
                        pe_set   = ~stop_bad & par_bad_q & (PARITY != 0);
                        push_req = ~stop_bad & ~(par_bad_q & (PARITY != 0));
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign full     = (count_q == FULL_COUNT);
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    // a pop in the same cycle frees a slot, so a push into a full FIFO is still taken
    assign push     = push_req & (~full | pop);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            frame_err_q  <= fe_set;
            parity_err_q <= pe_set;
            if (push_req && full && !pop) overrun_q <= 1'b1;
            else if (clr_err)             overrun_q <= 1'b0;
        end
    end

    assign rd_data    = mem_q[rptr_q];
    assign count      = count_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one 8N1 instance and one even-parity instance, both with a
// 4-entry FIFO, checked against a frame-level queue model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1, rx_p = 1'b1;
    logic       rdy_a = 1'b0, rdy_p = 1'b0;
    logic       clr_a = 1'b0, clr_p = 1'b0;
    logic [7:0] rdd_a, rdd_p;
    logic       rdv_a, rdv_p;
    logic [2:0] cnt_a, cnt_p;
    logic       fe_a, pe_a, ovr_a, fe_p, pe_p, ovr_p;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt_a = 0, pe_cnt_a = 0, fe_cnt_p = 0, pe_cnt_p = 0;
    int exp_fe_a = 0, exp_fe_p = 0, exp_pe_p = 0;
    bit exp_ovr_a = 0, exp_ovr_p = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_p[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_dut (
        .CLK(clk), .reset(reset), .rx(rx_a), .rd_data(rdd_a), .rd_valid(rdv_a), .rd_ready(rdy_a),
        .count(cnt_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .clr_err(clr_a));

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_par (
        .CLK(clk), .reset(reset), .rx(rx_p), .rd_data(rdd_p), .rd_valid(rdv_p), .rd_ready(rdy_p),
        .count(cnt_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ovr_p), .clr_err(clr_p));

    always @(posedge clk) begin
        if (fe_a) fe_cnt_a++;
        if (pe_a) pe_cnt_a++;
        if (fe_p) fe_cnt_p++;
        if (pe_p) pe_cnt_p++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bit(input int line, input logic b);
        @(negedge clk);
        if (line == 0) rx_a = b; else rx_p = b;
        repeat (15) @(negedge clk);
    endtask

    task automatic send(input int line, input logic [7:0] d, input bit has_par,
                        input logic pbit, input logic stop);
        drive_bit(line, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
        if (has_par) drive_bit(line, pbit);
        drive_bit(line, stop);
        if (!stop) drive_bit(line, 1'b1);
    endtask

    task automatic model_frame(input int line, input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!stop_ok) begin
            if (line == 0) exp_fe_a++; else exp_fe_p++;
        end else if (!par_ok) begin
            exp_pe_p++;
        end else if (line == 0) begin
            if (q_a.size() < 4) q_a.push_back(d); else exp_ovr_a = 1;
        end else begin
            if (q_p.size() < 4) q_p.push_back(d); else exp_ovr_p = 1;
        end
    endtask

    task automatic read_one(input int line);
        @(negedge clk);
        if (line == 0) begin
            chk("rd_valid_a", {31'd0, rdv_a}, {31'd0, q_a.size() != 0});
            if (q_a.size() != 0) begin
                chk("rd_data_a", {24'd0, rdd_a}, {24'd0, q_a.pop_front()});
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
            end
        end else begin
            chk("rd_valid_p", {31'd0, rdv_p}, {31'd0, q_p.size() != 0});
            if (q_p.size() != 0) begin
                chk("rd_data_p", {24'd0, rdd_p}, {24'd0, q_p.pop_front()});
                rdy_p = 1'b1;
                @(negedge clk);
                rdy_p = 1'b0;
            end
        end
    endtask

    task automatic check_a(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, {29'd0, cnt_a}, q_a.size());
        chk({tag, "_ovr"}, {31'd0, ovr_a}, {31'd0, exp_ovr_a});
        chk({tag, "_fe"}, fe_cnt_a, exp_fe_a);
        chk({tag, "_pe"}, pe_cnt_a, 0);
    endtask

    task automatic check_p(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, {29'd0, cnt_p}, q_p.size());
        chk({tag, "_ovr"}, {31'd0, ovr_p}, {31'd0, exp_ovr_p});
        chk({tag, "_fe"}, fe_cnt_p, exp_fe_p);
        chk({tag, "_pe"}, pe_cnt_p, exp_pe_p);
    endtask

    task automatic pulse_clr_a();
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        exp_ovr_a = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] seq[5];
        bit stop_ok, par_ok;

        repeat (4) @(negedge clk);
        chk("rst_rd_valid_a", {31'd0, rdv_a}, 0);
        chk("rst_count_a", {29'd0, cnt_a}, 0);
        chk("rst_errs_a", {29'd0, fe_a, pe_a, ovr_a}, 0);
        chk("rst_rd_valid_p", {31'd0, rdv_p}, 0);
        chk("rst_errs_p", {29'd0, fe_p, pe_p, ovr_p}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_a("idle");

        // basic framing
        send(0, 8'hF4, 0, 1'b0, 1'b1);
        model_frame(0, 8'hF4, 1, 1);
        check_a("basic");
        chk("basic_valid", {31'd0, rdv_a}, 1);
        chk("basic_data", {24'd0, rdd_a}, 32'hF4);
        read_one(0);
        check_a("basic_read");

        // ordering and overrun
        seq = '{8'h7E, 8'h03, 8'h55, 8'h57, 8'hFE};
        for (int i = 0; i < 5; i++) begin
            send(0, seq[i], 0, 1'b0, 1'b1);
            model_frame(0, seq[i], 1, 1);
        end
        check_a("order");
        chk("order_ovr_set", {31'd0, ovr_a}, 1);
        for (int i = 0; i < 4; i++) read_one(0);
        read_one(0);
        pulse_clr_a();
        check_a("order_clr");

        // full boundary: pop coincides with the push cycle
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send(0, d, 0, 1'b0, 1'b1);
            model_frame(0, d, 1, 1);
        end
        check_a("fill");
        fork
            send(0, 8'hC0, 0, 1'b0, 1'b1);
            begin
                repeat (155) @(negedge clk);
                chk("fullb_head", {24'd0, rdd_a}, {24'd0, q_a[0]});
                chk("fullb_count_pre", {29'd0, cnt_a}, 4);
                rdy_a = 1'b1;
                @(negedge clk);
                rdy_a = 1'b0;
            end
        join
        void'(q_a.pop_front());
        q_a.push_back(8'hC0);
        check_a("fullb");
        for (int i = 0; i < 4; i++) read_one(0);
        check_a("fullb_drain");

        // framing error and glitch
        send(0, 8'h7E, 0, 1'b0, 1'b0);
        model_frame(0, 8'h7E, 1, 0);
        repeat (20) @(negedge clk);
        check_a("frame_err");
        @(negedge clk);
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);
        check_a("glitch");
        chk("glitch_valid", {31'd0, rdv_a}, 0);

        // parity
        send(1, 8'h41, 1, 1'b0, 1'b1);
        model_frame(1, 8'h41, 1, 1);
        check_p("par_good");
        read_one(1);
        send(1, 8'h41, 1, 1'b1, 1'b1);
        model_frame(1, 8'h41, 0, 1);
        check_p("par_bad");

        // randomized 8N1 traffic
        for (int it = 0; it < 30; it++) begin
            d = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            send(0, d, 0, 1'b0, stop_ok);
            model_frame(0, d, 1, stop_ok);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            check_a("rand_a");
            for (int r = $urandom_range(0, 3); r > 0; r--) read_one(0);
            if ($urandom_range(0, 3) == 0) pulse_clr_a();
            check_a("rand_a_post");
        end

        // randomized parity traffic
        for (int it = 0; it < 12; it++) begin
            d = 8'($urandom);
            par_ok  = ($urandom_range(0, 2) != 0);
            stop_ok = ($urandom_range(0, 4) != 0);
            send(1, d, 1, (^d) ^ !par_ok, stop_ok);
            model_frame(1, d, par_ok, stop_ok);
            check_p("rand_p");
            while (q_p.size() != 0) read_one(1);
        end

        // reset during bit 3 of 0xF0, released while the line is still low
        fork
            send(0, 8'hF0, 0, 1'b0, 1'b1);
            begin
                repeat (70) @(negedge clk);
                reset = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
            end
        join
        q_a.delete();
        q_p.delete();
        exp_ovr_a = 0;
        exp_ovr_p = 0;
        repeat (20) @(negedge clk);
        check_a("rst_mid");
        chk("rst_mid_valid", {31'd0, rdv_a}, 0);
        send(0, 8'hFF, 0, 1'b0, 1'b1);
        model_frame(0, 8'hFF, 1, 1);
        check_a("rst_after");
        read_one(0);
        check_p("final_p");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO and error reporting, replacing the fixed 8N1 receive path that feeds the LED shift register in `ClockBaseTop`. It takes the raw asynchronous RX pin and frames characters of configurable width, parity and stop length at a fixed bit period. It queues good characters in a first-word-fall-through FIFO with a valid/ready read port. The default configuration matches the current bench link: 100 MHz `CLK`, 17 360 ns bit, 8 data bits, no parity, 1 stop bit.

## Interface
- `CLKS_PER_BIT`, default 1736: `CLK` cycles per bit; must be ≥ 4.
- `DATA_BITS`, default 8: character width, 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `DEPTH`, default 16: FIFO entries, power of two ≥ 2.

Ports:
- `CLK` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: UART line; asynchronous; idle high.
- `rd_data` out `DATA_BITS`: FIFO head; valid only while `rd_valid` = 1.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts the head.
- `count` out `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `frame_err` out 1: one-cycle pulse; stop bit was sampled low.
- `parity_err` out 1: one-cycle pulse; parity mismatch.
- `overrun` out 1: sticky; a good character arrived while the FIFO was full.
- `clr_err` in 1: synchronous clear of `overrun`.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchroniser, reset to 1. All logic below uses the synchronised value `rxs`.
- **Arming:** after reset the receiver is disarmed. It arms only after `rxs` has been seen high, so a reset released mid-frame cannot cause a false start.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START:** armed and `rxs` = 0; the bit counter loads `CLKS_PER_BIT/2 - 1`.
- **START, at the mid-bit sample:**
  - `rxs` = 0: go to DATA, counter reloads `CLKS_PER_BIT - 1`.
  - `rxs` = 1: glitch; return to IDLE with no output and no error.
- **DATA:** samples `DATA_BITS` bits, LSB first, one per `CLKS_PER_BIT`. Then go to PARITY if `PARITY` ≠ 0, otherwise STOP.
- **PARITY:**
  - Odd mode: data XOR parity bit must be 1.
  - Even mode: data XOR parity bit must be 0.
- **STOP:** samples `STOP_BITS` bits. Any stop sample of 0 is a framing error.
- **End of frame (last stop sample):**
  - Framing error: pulse `frame_err`; character discarded.
  - Otherwise, parity error: pulse `parity_err`; character discarded.
  - Framing error takes precedence; at most one pulse per frame.
  - Good character, FIFO not full: push.
  - Good character, FIFO full: drop and set `overrun`.
- **Back to IDLE:** immediately after the last stop sample, with no wait for a full stop period. The next start edge is detected from the following cycle.
- **FIFO read:** a pop occurs when `rd_valid && rd_ready`; `rd_data` is the head combinationally from the storage array.
- **Push and pop in the same cycle:** both take effect; `count` is unchanged.
  - This also holds when full: the pop frees a slot, so the push is accepted and `overrun` is not set.
  - When empty, no pop can occur, so the push simply lands.
- **Pointers:** `$clog2(DEPTH)` bits, wrap modulo `DEPTH`. `count` is a separate up/down counter.
- **`overrun`:** set has priority over `clr_err` in the same cycle.

## Timing
- **Reset values (asynchronous):**
  - state = IDLE, disarmed.
  - `rd_valid` = 0, `count` = 0.
  - `frame_err` = 0, `parity_err` = 0, `overrun` = 0.
  - Pointers 0; `rd_data` content is don't-care.
- **Reset mid-frame:** the partial character is lost and the FIFO is emptied.
- **Start detection:** 2 cycles of synchroniser latency plus 1 cycle of edge detect.
- **Sample instants:** the first sample (start check) comes `CLKS_PER_BIT/2` cycles after detection; each later sample follows at `CLKS_PER_BIT`-cycle intervals.
- **Push latency:** `rd_valid` rises 1 cycle after the last stop-bit sample. Error pulses are asserted in that same cycle.
- **Pop latency:** `count` and `rd_valid` update on the edge following the pop cycle.
- **Baud tolerance:** ±4 % total clock mismatch at `CLKS_PER_BIT` ≥ 16.

## Test plan
- **Basic framing:** defaults with `CLKS_PER_BIT` = 16; send 0xF4 as 8N1, `rd_ready` = 0 → `rd_valid` = 1 with `rd_data` = 0xF4, `count` = 1, no error pulses.
- **Ordering and overrun:** `DEPTH` = 4; send 0x7E, 0x03, 0x55, 0x57, 0xFE back-to-back with no reads → `count` = 4, `overrun` = 1. Reads return 0x7E, 0x03, 0x55, 0x57; 0xFE is lost; `clr_err` then clears `overrun`.
- **Parity:** `PARITY` = 2; send 0x41 with the correct parity bit (0) → accepted. Send 0x41 with parity bit 1 → one `parity_err` pulse, `count` unchanged.
- **Framing error and glitch:**
  - Send 0x7E with the stop bit forced 0 → one `frame_err` pulse, nothing pushed.
  - A 3-cycle low glitch on idle `rx` → no state change beyond START, no push, no pulse.
- **Full boundary:** `DEPTH` = 4, FIFO full; drop `rd_ready` high for exactly one cycle coincident with the push cycle of character 0xC0 → `count` stays 4, `overrun` = 0, and 0xC0 is read last.
- **Reset behaviour:** assert `reset` during bit 3 of 0xF0, release while `rx` is still low → no push, no false start. The next clean 0xFF is received correctly, and `count` = 1.
